// File: rtl/frac_lut6_cfg_loader.sv
// Configuration writer for one fractured 6-input LUT: streams a 72-bit frame in,
// validates it and commits truth table + fracture mode atomically. Optional parity
// word check is compiled in with `define FRAC_LUT6_CFG_PARITY_EN.
module frac_lut6_cfg_loader #(
  parameter int DATA_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [0:63]       sram,
  output logic [0:63]       sram_inv,
  output logic [0:0]        mode,
  output logic [0:0]        mode_inv
);

  localparam int FRAME_W = 72;
  localparam int WORDS   = FRAME_W / DATA_W;
  localparam int CNT_W   = $clog2(WORDS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
`ifdef FRAC_LUT6_CFG_PARITY_EN
  localparam logic [1:0] CHECK  = 2'd2;
`endif
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   word_cnt;
  logic [FRAME_W-1:0] shadow;
  logic               accept;
  logic               last_word;
  logic               commit_ok;

  // Shadow holds frame bit 0 in its MSB once all words have been shifted in.
  function automatic logic [0:63] frame_sram(input logic [63:0] f);
    logic [0:63] r;
    for (int i = 0; i < 64; i++) begin
      r[i] = f[63-i];
    end
    return r;
  endfunction

  function automatic logic frame_pad_ok(input logic [6:0] pad);
    return (pad == 7'd0);
  endfunction

  assign cfg_ready = (state == LOAD)
`ifdef FRAC_LUT6_CFG_PARITY_EN
                   | (state == CHECK)
`endif
                   ;
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign last_word = (word_cnt == CNT_W'(WORDS - 1));

`ifdef FRAC_LUT6_CFG_PARITY_EN
  logic [DATA_W-1:0] par_acc;
  logic              par_ok;

  // Running XOR of the data words; the trailing word must reproduce it.
  always_ff @(posedge prog_clk) begin
    if (state == IDLE && start) begin
      par_acc <= '0;
    end else if (state == LOAD && accept) begin
      par_acc <= par_acc ^ cfg_data;
    end
    if (state == CHECK && accept) begin
      par_ok <= (cfg_data == par_acc);
    end
  end

  assign commit_ok = frame_pad_ok(shadow[6:0]) & par_ok;
`else
  assign commit_ok = frame_pad_ok(shadow[6:0]);
`endif

  // Frame assembly: datapath only, cleared at frame start
  always_ff @(posedge prog_clk) begin
    if (state == IDLE && start) begin
      shadow <= '0;
    end else if (state == LOAD && accept) begin
      shadow <= {shadow[FRAME_W-DATA_W-1:0], cfg_data};
    end
  end

  // Control FSM and active configuration registers
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state    <= IDLE;
      word_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      sram     <= '0;
      sram_inv <= '1;
      mode     <= 1'b0;
      mode_inv <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            word_cnt <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (last_word) begin
`ifdef FRAC_LUT6_CFG_PARITY_EN
              state <= CHECK;
`else
              state <= COMMIT;
`endif
            end
          end
        end
`ifdef FRAC_LUT6_CFG_PARITY_EN
        CHECK: begin
          if (accept) begin
            state <= COMMIT;
          end
        end
`endif
        COMMIT: begin
          // True and complement rails are loaded in the same edge.
          if (commit_ok) begin
            sram     <= frame_sram(shadow[71:8]);
            sram_inv <= ~frame_sram(shadow[71:8]);
            mode     <= shadow[7];
            mode_inv <= ~shadow[7];
            done     <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Self-checking bench for frac_lut6_cfg_loader (DATA_W=8) with a frame-level
// reference model; follows FRAC_LUT6_CFG_PARITY_EN when defined.
module tb_frac_lut6_cfg_loader;
  localparam int DW    = 8;
  localparam int WORDS = 72 / DW;
  typedef logic [DW-1:0] word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cfg_valid;
  logic        cfg_ready;
  word_t       cfg_data;
  logic        busy, done, err;
  logic [0:63] sram, sram_inv;
  logic [0:0]  mode, mode_inv;

  int checks = 0;
  int fails  = 0;

  logic [0:63] exp_sram;
  logic        exp_mode;

  frac_lut6_cfg_loader #(.DATA_W(DW)) dut (
    .prog_clk(clk), .pReset(rst), .start(start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .busy(busy), .done(done),
    .err(err), .sram(sram), .sram_inv(sram_inv), .mode(mode), .mode_inv(mode_inv)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(cfg_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_sram"}, sram, 64'd0);
    chk({tag, "_sram_inv"}, sram_inv, {64{1'b1}});
    chk({tag, "_mode"}, 64'(mode), 64'd0);
    chk({tag, "_mode_inv"}, 64'(mode_inv), 64'd1);
  endtask

  // Append the parity word when the parity build is under test.
  function automatic void finish_frame(inout word_t q[$]);
`ifdef FRAC_LUT6_CFG_PARITY_EN
    word_t x = '0;
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
`else
    q = q;
`endif
  endfunction

  // Reference: frame bit k is bit (DW-1 - k%DW) of word k/DW.
  function automatic bit model_frame(input word_t q[$], output logic [0:63] s, output logic m);
    logic fb [0:71];
    bit ok = 1'b1;
    word_t x = '0;
    for (int k = 0; k < 72; k++) fb[k] = q[k / DW][DW - 1 - (k % DW)];
    for (int k = 0; k < 64; k++) s[k] = fb[k];
    m = fb[64];
    for (int k = 65; k < 72; k++) if (fb[k]) ok = 1'b0;
`ifdef FRAC_LUT6_CFG_PARITY_EN
    for (int i = 0; i < WORDS; i++) x ^= q[i];
    if (q[WORDS] != x) ok = 1'b0;
`else
    x = q[0];
`endif
    return ok;
  endfunction

  // Sends one frame; chained_in means the loader is already in LOAD.
  // chain_out issues start in the done/err cycle and leaves the loader in LOAD.
  task automatic run_frame(input string tag, input word_t q[$], input bit stall,
                           input bit start_noise, input bit chained_in, input bit chain_out);
    int i = 0;
    int cyc = 0;
    bit v, rdy, ok;
    logic [0:63] s;
    logic m;
    ok = model_frame(q, s, m);
    if (!chained_in) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_start"}, 64'(busy), 64'd1);
      chk({tag, "_ready_start"}, 64'(cfg_ready), 64'd1);
    end
    while (i < q.size() && cyc < 1000) begin
      v = stall ? cyc[0] : 1'b1;
      cfg_valid = v;
      cfg_data  = v ? q[i] : word_t'($urandom);
      start     = start_noise ? 1'($urandom) : 1'b0;
      rdy = cfg_ready;
      step();
      if (v && rdy) i++;
      cyc++;
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    chk({tag, "_words_taken"}, 64'(i), 64'(q.size()));
    chk({tag, "_load_cycles"}, 64'(cyc), 64'(stall ? 2 * q.size() : q.size()));
    chk({tag, "_commit_busy"}, 64'(busy), 64'd1);
    chk({tag, "_commit_ready"}, 64'(cfg_ready), 64'd0);
    chk({tag, "_commit_nodone"}, 64'({done, err}), 64'd0);
    cfg_valid = 1'b1;
    cfg_data  = word_t'($urandom);
    step();
    cfg_valid = 1'b0;
    if (ok) begin
      exp_sram = s;
      exp_mode = m;
    end
    chk({tag, "_done"}, 64'(done), 64'(ok));
    chk({tag, "_err"}, 64'(err), 64'(!ok));
    chk({tag, "_sram"}, sram, exp_sram);
    chk({tag, "_sram_inv"}, sram_inv, ~exp_sram);
    chk({tag, "_mode"}, 64'({mode, mode_inv}), 64'({exp_mode, ~exp_mode}));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    start = chain_out;
    step();
    start = 1'b0;
    chk({tag, "_pulse_len"}, 64'({done, err}), 64'd0);
    if (chain_out) chk({tag, "_chain_busy"}, 64'({busy, cfg_ready}), 64'd3);
  endtask

  initial begin
    word_t q[$];
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    exp_sram = '0; exp_mode = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset_vals("reset");
    cfg_valid = 1'b1;
    step();
    chk("idle_ready", 64'({cfg_ready, busy}), 64'd0);
    cfg_valid = 1'b0;

    // Alternating pattern with mode bit set
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'hAA);
    q.push_back(8'h80);
    finish_frame(q);
    run_frame("alt", q, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alt_sram_lit", sram, {32{2'b10}});
    chk("alt_mode_lit", 64'({mode, mode_inv}), 64'd2);

    // Pad bit set: rejected, configuration kept
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'hAA);
    q.push_back(8'h81);
    finish_frame(q);
    run_frame("pad", q, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pad_sram_kept", sram, {32{2'b10}});

    // Stalled frame, all ones, mode 0
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'hFF);
    q.push_back(8'h00);
    finish_frame(q);
    run_frame("stall", q, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_sram_lit", sram, {64{1'b1}});

`ifdef FRAC_LUT6_CFG_PARITY_EN
    q = {};
    for (int i = 1; i <= 8; i++) q.push_back(word_t'(i));
    q.push_back(8'h00);
    q.push_back(8'h08);
    run_frame("par_ok", q, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_ok_lit", 64'(done | (sram == 64'h0102030405060708)), 64'd1);
    q[WORDS] = 8'h09;
    q[0] = 8'h55;
    run_frame("par_bad", q, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_bad_kept", sram, 64'h0102030405060708);
`endif

    // Reset mid-frame after four words
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'h5A;
      step();
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_sram = '0;
    exp_mode = 1'b0;
    chk_reset_vals("midrst");
    step();
    chk("midrst_quiet", 64'({done, err, busy}), 64'd0);

    // Randomised frames: stalls, start noise, pad errors, back-to-back chaining
    for (int f = 0; f < 24; f++) begin
      bit chain_in = (f > 0) && (f % 4 != 0);
      q = {};
      for (int i = 0; i < WORDS - 1; i++) q.push_back(word_t'($urandom));
      q.push_back({1'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0});
      finish_frame(q);
`ifdef FRAC_LUT6_CFG_PARITY_EN
      if ($urandom_range(0, 3) == 0) q[WORDS] ^= word_t'($urandom_range(1, 255));
`endif
      run_frame($sformatf("rnd%0d", f), q, 1'($urandom), 1'b1, chain_in, (f % 4 != 3));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
